// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: shared state encoding and defaults for the program loader.
package instruction_loader_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
  localparam int BYTES_PER_WORD = 32 / 8;
  function automatic int bytes_per_word(input int word_width, input int byte_width);
    return word_width / byte_width;
  endfunction
endpackage

// File: rtl/instruction_loader_word_assembler.sv
// word_assembler: packs an MSB-first byte stream into words and flags each completed word.
module word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [BYTE_WIDTH-1:0] data,
  input  logic                  valid,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_ready
);
  localparam int BPW = bytes_per_word(WORD_WIDTH, BYTE_WIDTH);
  localparam int CW = BPW > 1 ? $clog2(BPW) : 1;
  logic [CW-1:0] cnt;
  assign word_ready = valid && !clear && cnt == CW'(BPW - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (valid) begin
      word <= {word[WORD_WIDTH-BYTE_WIDTH-1:0], data};
      cnt  <= word_ready ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: assembles a byte stream into instructions and writes them to
// consecutive instruction-memory words until the halt word (or memory end) is reached.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int                    MEM_SIZE    = 1024,
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    ADDR_LENGTH = 32,
  parameter int                    BYTE_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0] HALT_WORD   = WORD_WIDTH'(DEF_HALT_WORD)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [BYTE_WIDTH-1:0]  i_byte,
  input  logic                   i_byte_valid,
  output logic                   o_wr_en,
  output logic [ADDR_LENGTH-1:0] o_wr_addr,
  output logic [WORD_WIDTH-1:0]  o_wr_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overflow
);
  state_t                  state, next;
  logic [ADDR_LENGTH-1:0]  addr;
  logic [WORD_WIDTH-1:0]   word;
  logic                    word_ready, is_halt, last_addr, accept;
  assign is_halt   = word == HALT_WORD;
  assign last_addr = addr == ADDR_LENGTH'(MEM_SIZE - 1);
  // A byte landing in WRITE starts the next word only if loading continues.
  assign accept = i_byte_valid && !i_start &&
                  (state == RECV || (state == WRITE && !is_halt && !last_addr));
  word_assembler #(.WORD_WIDTH(WORD_WIDTH), .BYTE_WIDTH(BYTE_WIDTH)) u_asm (
    .clk        (i_clk),
    .rst        (i_reset),
    .clear      (i_start),
    .data       (i_byte),
    .valid      (accept),
    .word       (word),
    .word_ready (word_ready)
  );
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    next = i_start                      ? RECV  :
           state == RECV && word_ready  ? WRITE :
           state == WRITE               ? (is_halt ? DONE : last_addr ? ERROR : RECV) :
                                          state;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) addr <= '0;
    else if (i_start) addr <= '0;
    else if (state == WRITE && next == RECV) addr <= addr + 1'b1;
  assign o_wr_en    = state == WRITE;
  assign o_wr_addr  = addr;
  assign o_wr_data  = word;
  assign o_busy     = state == RECV || state == WRITE;
  assign o_done     = state == DONE;
  assign o_overflow = state == ERROR;
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed checks of the byte-stream instruction loader (MEM_SIZE=4).
module tb_instruction_loader;
  logic        i_clk = 0, i_reset = 1, i_start = 0, i_byte_valid = 0;
  logic [7:0]  i_byte = 0;
  logic        o_wr_en, o_busy, o_done, o_overflow;
  logic [31:0] o_wr_addr, o_wr_data;
  logic [63:0] wlog[$];
  int          n_checks = 0, n_fail = 0;

  instruction_loader #(.MEM_SIZE(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_byte(i_byte),
    .i_byte_valid(i_byte_valid), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;
  always @(negedge i_clk) if (o_wr_en) wlog.push_back({o_wr_addr, o_wr_data});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic s);
    i_byte_valid = v;
    i_byte = b;
    i_start = s;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) step(1, w[i*8+:8], 0);
  endtask

  task automatic gap_byte(input logic [7:0] b);
    step(1, b, 0);
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic check_log(input string tag, input logic [31:0] exp_d[$]);
    check({tag, "_count"}, 64'(wlog.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      check({tag, "_addr"}, 64'(wlog[i][63:32]), 64'(i));
      check({tag, "_data"}, 64'(wlog[i][31:0]), 64'(exp_d[i]));
    end
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_wr_en", 64'(o_wr_en), 0);
    check("rst_addr", 64'(o_wr_addr), 0);
    check("rst_data", 64'(o_wr_data), 0);
    check("rst_busy", 64'(o_busy), 0);
    check("rst_done", 64'(o_done), 0);
    check("rst_ovf", 64'(o_overflow), 0);
    i_reset = 0;
    step(1, 8'h77, 0);
    check("idle_ignores_bytes", 64'(o_busy), 0);

    step(0, 0, 1);
    check("start_busy", 64'(o_busy), 1);
    step(1, 8'h20, 0);
    step(1, 8'h01, 0);
    step(1, 8'h00, 0);
    check("pre_wr_en", 64'(o_wr_en), 0);
    step(1, 8'h05, 0);
    check("w1_wr_en", 64'(o_wr_en), 1);
    check("w1_addr", 64'(o_wr_addr), 0);
    check("w1_data", 64'(o_wr_data), 64'h2001_0005);
    check("w1_busy", 64'(o_busy), 1);
    step(0, 0, 0);
    check("w1_strobe_one_cycle", 64'(o_wr_en), 0);

    wlog.delete();
    step(0, 0, 1);
    send_word(32'h1122_3344);
    send_word(32'h5566_7788);
    send_word(32'h99AA_BBCC);
    send_word(32'hFFFF_FFFF);
    check("halt_wr_en", 64'(o_wr_en), 1);
    check("halt_addr", 64'(o_wr_addr), 3);
    check("halt_data", 64'(o_wr_data), 64'hFFFF_FFFF);
    step(0, 0, 0);
    check("halt_done", 64'(o_done), 1);
    check("halt_busy", 64'(o_busy), 0);
    check("halt_hold_addr", 64'(o_wr_addr), 3);
    send_word(32'h0102_0304);
    check("done_still", 64'(o_done), 1);
    check_log("halt_log", '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hFFFF_FFFF});

    wlog.delete();
    step(0, 0, 1);
    check("restart_done_clr", 64'(o_done), 0);
    send_word(32'h0101_0101);
    send_word(32'h0202_0202);
    send_word(32'h0303_0303);
    send_word(32'h0404_0404);
    step(1, 8'h09, 0);
    check("ovf_flag", 64'(o_overflow), 1);
    check("ovf_done", 64'(o_done), 0);
    check("ovf_busy", 64'(o_busy), 0);
    send_word(32'h0505_0505);
    check_log("ovf_log", '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404});

    wlog.delete();
    step(0, 0, 1);
    check("restart_ovf_clr", 64'(o_overflow), 0);
    gap_byte(8'hDE);
    gap_byte(8'hAD);
    gap_byte(8'hBE);
    step(1, 8'hEF, 0);
    step(1, 8'hCA, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    gap_byte(8'hFE);
    gap_byte(8'hF0);
    step(1, 8'h0D, 0);
    step(0, 0, 0);
    check_log("gap_log", '{32'hDEAD_BEEF, 32'hCAFE_F00D});

    step(0, 0, 1);
    step(1, 8'hAA, 0);
    step(1, 8'hBB, 0);
    step(1, 8'hCC, 1);
    send_word(32'h1234_5678);
    check("partial_wr_en", 64'(o_wr_en), 1);
    check("partial_addr", 64'(o_wr_addr), 0);
    check("partial_data", 64'(o_wr_data), 64'h1234_5678);

    step(0, 0, 0);
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    check("pre_areset_addr", 64'(o_wr_addr), 1);
    #2 i_reset = 1;
    #1;
    check("areset_addr", 64'(o_wr_addr), 0);
    check("areset_data", 64'(o_wr_data), 0);
    check("areset_busy", 64'(o_busy), 0);
    check("areset_wr_en", 64'(o_wr_en), 0);
    #2 i_reset = 0;
    wlog.delete();
    send_word(32'hAABB_CCDD);
    step(0, 0, 0);
    check("post_reset_no_write", 64'(wlog.size()), 0);
    check("post_reset_busy", 64'(o_busy), 0);
    check("post_reset_data", 64'(o_wr_data), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Write-side counterpart of the instruction memory.
- Receives the program as a byte stream (from the debug/UART path), packs each 4 bytes into a 32-bit instruction, and issues one write strobe per word into instruction memory at consecutive word addresses.
- Loading stops at the halt word, which is itself written.
- Instruction memory is word-indexed, so the address increments by 1 per word.

Parameters:
- MEM_SIZE, 1024, instruction memory depth in words.
- WORD_WIDTH, 32, instruction width.
- ADDR_LENGTH, 32, width of write address.
- BYTE_WIDTH, 8, width of incoming stream symbols; WORD_WIDTH is an exact multiple of it.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  single-cycle pulse: begin (or restart) a load at address 0.
- i_byte  input  BYTE_WIDTH  incoming program byte.
- i_byte_valid  input  1  i_byte is valid this cycle; one byte consumed per asserted cycle, no backpressure.
- o_wr_en  output  1  one-cycle write strobe to instruction memory.
- o_wr_addr  output  ADDR_LENGTH  word address for the write.
- o_wr_data  output  WORD_WIDTH  assembled instruction.
- o_busy  output  1  high in RECV and WRITE.
- o_done  output  1  halt word written; held until next i_start.
- o_overflow  output  1  memory filled without a halt word; held until next i_start.

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is asynchronous, active-high.
- Reset values:
  - state=IDLE.
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0.
  - o_busy=0, o_done=0, o_overflow=0.
  - Byte counter=0, assembly register=0.
- Registered outputs: all outputs come from registers or decode of the state register. There is no combinational path from inputs to outputs.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE:
  - i_byte_valid is ignored.
  - i_start -> RECV, with addr=0, byte counter=0, o_done=0, o_overflow=0.
- RECV:
  - Each i_byte_valid shifts the byte in MSB-first: word <= {word[WORD_WIDTH-BYTE_WIDTH-1:0], i_byte}, and the counter increments.
  - On acceptance of the 4th byte (counter 3 -> 0), next state = WRITE.
- WRITE (exactly one cycle):
  - o_wr_en=1, o_wr_data=assembled word, o_wr_addr=current addr.
  - Next state:
    - word==HALT_WORD -> DONE.
    - else addr==MEM_SIZE-1 -> ERROR.
    - else addr+1 -> RECV.
- Latency: 4th byte sampled at edge N; o_wr_en high during the cycle following edge N (between N and N+1). Back-to-back bytes are therefore never lost.
- Byte arriving during WRITE:
  - If the next state is RECV, it is accepted as byte 0 of the next word (counter=1).
  - If the next state is DONE or ERROR, it is dropped.
- DONE: o_done=1, o_busy=0. o_wr_addr holds the halt word's address. Bytes are ignored.
- ERROR: o_overflow=1, o_busy=0. Bytes are ignored.
- i_start:
  - From any state, i_start returns to RECV with addr=0, counter=0, flags cleared.
  - i_start has priority over a simultaneous i_byte_valid; that byte is dropped.
  - i_start in WRITE suppresses nothing: the strobe for the current word still occurs, then the restart takes effect.
- Partial word: a partial word (fewer than 4 bytes) is never written. It is discarded on i_start or reset.
- Reset mid-load: returns to IDLE immediately; memory contents already written are left as is.
- Address arithmetic: unsigned; the address never exceeds MEM_SIZE-1.

Decomposition:
- Shared package:
  - State encoding localparams (3-bit: IDLE, RECV, WRITE, DONE, ERROR).
  - HALT_WORD default.
  - BYTES_PER_WORD = WORD_WIDTH/BYTE_WIDTH.
- Sub-module word_assembler:
  - Contains the shift register and byte counter.
  - Inputs: clear, byte, valid.
  - Outputs: word, word_ready.
- FSM and address counter stay in instruction_loader.

Test Plan:
- Reset then i_start, bytes 8'h20,8'h01,8'h00,8'h05 on consecutive cycles -> o_wr_en one cycle after 4th byte, o_wr_addr=0, o_wr_data=32'h20010005, o_busy=1.
- Stream 3 words then FF,FF,FF,FF -> writes at addr 0,1,2,3; word 3 = 32'hFFFFFFFF; o_done=1 next cycle, o_busy=0. Further bytes -> no o_wr_en.
- MEM_SIZE=4, 4 non-halt words -> writes at addr 0..3, then o_overflow=1, o_done=0.
- Bytes with gaps (valid every 3rd cycle) and a byte coinciding with a WRITE cycle -> no byte lost, words match expected packing.
- Send 2 bytes, pulse i_start together with a 3rd byte -> partial word discarded; next 4 bytes written at addr 0 with the correct value.
- Assert i_reset asynchronously mid-word (between edges) -> all outputs 0 immediately; bytes ignored until i_start.
